// File: rtl/alu_operand_seq_if.sv
// Instruction handshake bundle between an instruction source and alu_operand_seq.
// The source drives the instruction fields and valid; the sequencer answers with ready.
interface alu_operand_seq_if #(
  parameter int NREGS = 8
);
  localparam int AW = $clog2(NREGS);

  logic          instr_valid;
  logic          instr_ready;
  logic          instr_op;
  logic [AW-1:0] instr_rd;
  logic [AW-1:0] instr_rs1;
  logic [AW-1:0] instr_rs2;

  modport master (
    output instr_valid,
    output instr_op,
    output instr_rd,
    output instr_rs1,
    output instr_rs2,
    input  instr_ready
  );

  modport slave (
    input  instr_valid,
    input  instr_op,
    input  instr_rd,
    input  instr_rs1,
    input  instr_rs2,
    output instr_ready
  );
endinterface

// File: rtl/alu_operand_seq.sv
// Operand sequencer for the ADD/NOT ALU: owns the register file, issues one
// instruction at a time to the ALU and writes the registered result back.
//
// state | meaning
// IDLE  | ready for an instruction; register-file preload allowed
// ISSUE | operands driven to the ALU; carry captured at the closing edge
// WB    | ALU result written to rf[rd]; done pulse
module alu_operand_seq #(
  parameter int WIDTH = 32,
  parameter int NREGS = 8,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_operand_seq_if.slave instr,
  input  logic             init_we,
  input  logic [AW-1:0]    init_addr,
  input  logic [WIDTH-1:0] init_data,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_select,
  input  logic             alu_cout,
  input  logic [WIDTH-1:0] alu_result,
  output logic             done,
  output logic             carry,
  input  logic [AW-1:0]    dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WB    = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic             op_q;
  logic [AW-1:0]    rd_q;
  logic [AW-1:0]    rs1_q;
  logic [AW-1:0]    rs2_q;
  logic [WIDTH-1:0] rf [NREGS];
  logic             accept;

  assign accept = instr.instr_valid && instr.instr_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt         = state;
    instr.instr_ready = 1'b0;
    done              = 1'b0;
    alu_a             = '0;
    alu_b             = '0;
    alu_select        = 1'b0;
    case (state)
      IDLE: begin
        instr.instr_ready = 1'b1;
        if (instr.instr_valid) begin
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        // NOT only looks at A, so B is parked at zero rather than left on rs2.
        alu_a      = rf[rs1_q];
        alu_b      = op_q ? rf[rs2_q] : '0;
        alu_select = op_q;
        state_nxt  = WB;
      end
      WB: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= 1'b0;
      rd_q  <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
    end else if (accept) begin
      op_q  <= instr.instr_op;
      rd_q  <= instr.instr_rd;
      rs1_q <= instr.instr_rs1;
      rs2_q <= instr.instr_rs2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry <= 1'b0;
    end else if (state == ISSUE) begin
      carry <= op_q ? alu_cout : 1'b0;
    end
  end

  // Preload and writeback live in disjoint states, so one write port suffices.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        rf[i] <= '0;
      end
    end else if (state == IDLE && init_we) begin
      rf[init_addr] <= init_data;
    end else if (state == WB) begin
      rf[rd_q] <= alu_result;
    end
  end

  assign dbg_data = rf[dbg_addr];

endmodule

// File: tb/tb_alu_operand_seq.sv
// Scoreboard bench for alu_operand_seq with a behavioural ADD/NOT ALU model
// closing the loop between the operand outputs and the result input.
module tb_alu_operand_seq;
  localparam int WIDTH = 32;
  localparam int NREGS = 8;
  localparam int AW    = $clog2(NREGS);

  typedef struct {
    logic [WIDTH-1:0] value;
    logic             cy;
    int               done_cyc;
    string            name;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             init_we;
  logic [AW-1:0]    init_addr;
  logic [WIDTH-1:0] init_data;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic             alu_select;
  logic             alu_cout;
  logic [WIDTH-1:0] alu_result;
  logic             done;
  logic             carry;
  logic [AW-1:0]    dbg_addr;
  logic [WIDTH-1:0] dbg_data;
  logic [WIDTH:0]   alu_sum;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  exp_t sb[$];

  alu_operand_seq_if #(.NREGS(NREGS)) instr ();

  alu_operand_seq #(.WIDTH(WIDTH), .NREGS(NREGS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr      (instr.slave),
    .init_we    (init_we),
    .init_addr  (init_addr),
    .init_data  (init_data),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_select (alu_select),
    .alu_cout   (alu_cout),
    .alu_result (alu_result),
    .done       (done),
    .carry      (carry),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ALU model: combinational carry, result registered one edge after operands.
  assign alu_sum  = {1'b0, alu_a} + {1'b0, alu_b};
  assign alu_cout = alu_sum[WIDTH];
  always @(posedge clk) alu_result <= alu_select ? alu_sum[WIDTH-1:0] : ~alu_a;

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d expected no completion", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_result"}, alu_result, e.value);
        chk({e.name, "_carry"}, {31'd0, carry}, {31'd0, e.cy});
        chk({e.name, "_done_cycle"}, cyc, e.done_cyc);
      end
    end
  end

  task automatic preload(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    init_we   = 1'b1;
    init_addr = a;
    init_data = d;
    @(posedge clk);
    #1;
    init_we = 1'b0;
  endtask

  // Returns #1 after the accepting edge (DUT in ISSUE).
  task automatic issue(input string name, input logic op, input logic [AW-1:0] rd,
                       input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                       input logic [WIDTH-1:0] exp_val, input logic exp_cy, input bit push,
                       output int acc_cyc, output int waited);
    exp_t e;
    instr.instr_valid = 1'b1;
    instr.instr_op    = op;
    instr.instr_rd    = rd;
    instr.instr_rs1   = rs1;
    instr.instr_rs2   = rs2;
    waited = 0;
    @(negedge clk);
    while (!instr.instr_ready && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    if (!instr.instr_ready) begin
      checks++;
      errors++;
      $display("FAIL %s_accept_timeout: got ready=0 expected ready=1 within 20 cycles", name);
    end
    acc_cyc = cyc + 1;
    if (push) begin
      e.value    = exp_val;
      e.cy       = exp_cy;
      e.done_cyc = acc_cyc + 1;
      e.name     = name;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    instr.instr_valid = 1'b0;
  endtask

  task automatic wait_wb();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic rf_chk(input string name, input logic [AW-1:0] a, input logic [WIDTH-1:0] exp);
    dbg_addr = a;
    #1;
    chk(name, dbg_data, exp);
  endtask

  int acc1, acc2, w1, w2;

  initial begin
    rst_n             = 1'b0;
    init_we           = 1'b0;
    init_addr         = '0;
    init_data         = '0;
    dbg_addr          = '0;
    instr.instr_valid = 1'b0;
    instr.instr_op    = 1'b0;
    instr.instr_rd    = '0;
    instr.instr_rs1   = '0;
    instr.instr_rs2   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset asserted mid-ISSUE: the instruction must be dropped entirely.
    preload(3'd1, 32'd9);
    preload(3'd2, 32'd4);
    issue("rst_abort", 1'b1, 3'd3, 3'd1, 3'd2, 32'd0, 1'b0, 1'b0, acc1, w1);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", {31'd0, instr.instr_ready}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_carry", {31'd0, carry}, 32'd0);
    for (int i = 0; i < NREGS; i++) begin
      rf_chk($sformatf("rst_rf%0d", i), AW'(i), 32'd0);
    end

    // ADD 5 + 7
    @(posedge clk);
    #1;
    preload(3'd1, 32'd5);
    preload(3'd2, 32'd7);
    issue("add", 1'b1, 3'd3, 3'd1, 3'd2, 32'd12, 1'b0, 1'b1, acc1, w1);
    wait_wb();
    rf_chk("add_r3", 3'd3, 32'd12);
    chk("add_carry_hold", {31'd0, carry}, 32'd0);

    // NOT with B parked at zero during ISSUE
    preload(3'd1, 32'h0000_FFFF);
    issue("not", 1'b0, 3'd4, 3'd1, 3'd2, 32'hFFFF_0000, 1'b0, 1'b1, acc1, w1);
    chk("not_alu_a", alu_a, 32'h0000_FFFF);
    chk("not_alu_b", alu_b, 32'd0);
    chk("not_select", {31'd0, alu_select}, 32'd0);
    wait_wb();
    rf_chk("not_r4", 3'd4, 32'hFFFF_0000);
    chk("idle_alu_a", alu_a, 32'd0);

    // Wrap with carry, then NOT clears carry
    preload(3'd1, 32'hFFFF_FFFF);
    preload(3'd2, 32'd1);
    issue("wrap", 1'b1, 3'd5, 3'd1, 3'd2, 32'd0, 1'b1, 1'b1, acc1, w1);
    wait_wb();
    rf_chk("wrap_r5", 3'd5, 32'd0);
    chk("wrap_carry", {31'd0, carry}, 32'd1);
    issue("not_clr", 1'b0, 3'd6, 3'd2, 3'd1, 32'hFFFF_FFFE, 1'b0, 1'b1, acc1, w1);
    wait_wb();
    chk("not_clr_carry", {31'd0, carry}, 32'd0);

    // Back-to-back dependent instructions with valid held
    preload(3'd1, 32'd5);
    preload(3'd2, 32'd7);
    issue("b2b_first", 1'b1, 3'd3, 3'd1, 3'd2, 32'd12, 1'b0, 1'b1, acc1, w1);
    issue("b2b_dep", 1'b1, 3'd6, 3'd3, 3'd3, 32'd24, 1'b0, 1'b1, acc2, w2);
    chk("b2b_spacing", acc2 - acc1, 32'd3);
    chk("b2b_ready_low_cycles", w2, 32'd2);
    wait_wb();
    rf_chk("b2b_r6", 3'd6, 32'd24);

    // Preload coinciding with accept: instruction sees the new value
    init_we   = 1'b1;
    init_addr = 3'd1;
    init_data = 32'd100;
    issue("pre_acc", 1'b0, 3'd0, 3'd1, 3'd2, 32'hFFFF_FF9B, 1'b0, 1'b1, acc1, w1);
    init_we = 1'b0;
    wait_wb();
    rf_chk("pre_acc_r0", 3'd0, 32'hFFFF_FF9B);
    rf_chk("pre_acc_r1", 3'd1, 32'd100);

    // init_we to rd during ISSUE/WB must be ignored
    preload(3'd1, 32'd5);
    issue("init_busy", 1'b1, 3'd7, 3'd1, 3'd2, 32'd12, 1'b0, 1'b1, acc1, w1);
    init_we   = 1'b1;
    init_addr = 3'd7;
    init_data = 32'hDEAD_BEEF;
    wait_wb();
    init_we = 1'b0;
    rf_chk("init_busy_r7", 3'd7, 32'd12);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout: got no finish expected finish before 50000 time units");
    $fatal(1);
  end
endmodule
